// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: symbolic mnemonic ids, opcode/funct values
// and field-packing helpers used by the instruction encoder.
package mips_isa_pkg;

   typedef enum logic [4:0] {
      MN_ADD, MN_SUB, MN_AND, MN_OR, MN_SLT, MN_SLTU, MN_ADDU, MN_SUBU,
      MN_SLL, MN_NOR, MN_SRL, MN_SLLV, MN_SRLV, MN_JR, MN_JALR, MN_ADDI,
      MN_ORI, MN_LW, MN_SW, MN_BEQ, MN_LUI, MN_SLTI, MN_BNE, MN_ANDI,
      MN_J, MN_JAL
   } mnem_t;

   localparam int unsigned MNEM_ILLEGAL_MIN = 26;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;
   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, shamt, funct};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
      return {op, target};
   endfunction

endpackage

// File: rtl/mips_encode.sv
// Combinational encoder: symbolic mnemonic plus fields to a 32-bit MIPS word.
// Ids outside the mnemonic enum produce legal=0 and a zero word.
module mips_encode
   import mips_isa_pkg::*;
(
   input  logic [4:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = '0;
      legal = 1'b1;
      case (mnem)
         MN_ADD:  word = enc_r(rs, rt, rd, shamt, FN_ADD);
         MN_ADDU: word = enc_r(rs, rt, rd, shamt, FN_ADDU);
         MN_SUB:  word = enc_r(rs, rt, rd, shamt, FN_SUB);
         MN_SUBU: word = enc_r(rs, rt, rd, shamt, FN_SUBU);
         MN_AND:  word = enc_r(rs, rt, rd, shamt, FN_AND);
         MN_OR:   word = enc_r(rs, rt, rd, shamt, FN_OR);
         MN_NOR:  word = enc_r(rs, rt, rd, shamt, FN_NOR);
         MN_SLT:  word = enc_r(rs, rt, rd, shamt, FN_SLT);
         MN_SLTU: word = enc_r(rs, rt, rd, shamt, FN_SLTU);
         MN_SLL:  word = enc_r('0, rt, rd, shamt, FN_SLL);
         MN_SRL:  word = enc_r('0, rt, rd, shamt, FN_SRL);
         MN_SLLV: word = enc_r(rs, rt, rd, '0, FN_SLLV);
         MN_SRLV: word = enc_r(rs, rt, rd, '0, FN_SRLV);
         MN_JR:   word = enc_r(rs, '0, '0, '0, FN_JR);
         MN_JALR: word = enc_r(rs, '0, rd, '0, FN_JALR);
         MN_ADDI: word = enc_i(OP_ADDI, rs, rt, imm);
         MN_SLTI: word = enc_i(OP_SLTI, rs, rt, imm);
         MN_ANDI: word = enc_i(OP_ANDI, rs, rt, imm);
         MN_ORI:  word = enc_i(OP_ORI, rs, rt, imm);
         MN_LUI:  word = enc_i(OP_LUI, '0, rt, imm);
         MN_BEQ:  word = enc_i(OP_BEQ, rs, rt, imm);
         MN_BNE:  word = enc_i(OP_BNE, rs, rt, imm);
         MN_LW:   word = enc_i(OP_LW, rs, rt, imm);
         MN_SW:   word = enc_i(OP_SW, rs, rt, imm);
         MN_J:    word = enc_j(OP_J, target);
         MN_JAL:  word = enc_j(OP_JAL, target);
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/imem_encoder_loader.sv
// Encodes symbolic instruction requests and writes them to consecutive IM
// words through a stallable write port, tracking fill level and errors.
module imem_encoder_loader
   import mips_isa_pkg::*;
#(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned AW    = 7
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [4:0]    in_mnem,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_shamt,
   input  logic [15:0]   in_imm,
   input  logic [25:0]   in_target,
   output logic          im_we,
   input  logic          im_ack,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          err
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t      state, state_n;
   logic [AW:0] count_q, count_n;
   logic [31:0] wdata_q;
   logic        full_q, err_q;
   logic [31:0] enc_word;
   logic        enc_legal;
   logic        pending, commit, guard, accept, load;

   mips_encode u_enc (
      .mnem   (in_mnem),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .shamt  (in_shamt),
      .imm    (in_imm),
      .target (in_target),
      .word   (enc_word),
      .legal  (enc_legal)
   );

   // The write pointer equals the committed count, so one register serves both.
   assign pending  = (state == HOLD);
   assign commit   = pending & im_ack;
   assign guard    = ((count_q + (AW+1)'(pending)) == DEPTH_C);
   assign in_ready = ~clear & ~guard & (~pending | im_ack);
   assign accept   = in_valid & in_ready;
   assign load     = accept & enc_legal;
   assign count_n  = count_q + (AW+1)'(commit);

   assign im_we    = pending;
   assign im_addr  = count_q[AW-1:0];
   assign im_wdata = wdata_q;
   assign count    = count_q;
   assign full     = full_q;
   assign err      = err_q;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (load) state_n = HOLD;
         HOLD:    if (im_ack && !load) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state   <= IDLE;
         count_q <= '0;
         wdata_q <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_n;
         count_q <= count_n;
         full_q  <= (count_n == DEPTH_C);
         if (load) wdata_q <= enc_word;
         if (accept && !enc_legal) err_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_imem_encoder_loader.sv
// Directed bench for imem_encoder_loader: stimulus pushes expected writes into a
// scoreboard queue, a negedge monitor checks every presented IM write against it.
module tb_imem_encoder_loader;
   import mips_isa_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   word;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, clear, in_valid, im_ack;
   logic          in_ready, im_we, full, err;
   logic [4:0]    in_mnem, in_rs, in_rt, in_rd, in_shamt;
   logic [15:0]   in_imm;
   logic [25:0]   in_target;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic [AW:0]   count;

   exp_t          sb[$];
   logic [AW-1:0] exp_addr = '0;
   int            n_checks = 0;
   int            n_pass   = 0;

   always #5 clk = ~clk;

   imem_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mnem   (in_mnem),
      .in_rs     (in_rs),
      .in_rt     (in_rt),
      .in_rd     (in_rd),
      .in_shamt  (in_shamt),
      .in_imm    (in_imm),
      .in_target (in_target),
      .im_we     (im_we),
      .im_ack    (im_ack),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .count     (count),
      .full      (full),
      .err       (err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every presented write must match the oldest expected word; pop on ack.
   always @(negedge clk) begin
      if (!rst && im_we) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", {30'b0, im_addr}, 32'hFFFF_FFFF);
         end else begin
            chk("sb_addr", {{(32-AW){1'b0}}, im_addr}, {{(32-AW){1'b0}}, sb[0].addr});
            chk("sb_wdata", im_wdata, sb[0].word);
            if (im_ack) void'(sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sh,
                             input logic [15:0] imm, input logic [25:0] tgt);
      in_mnem = m; in_rs = rs; in_rt = rt; in_rd = rd;
      in_shamt = sh; in_imm = imm; in_target = tgt;
   endtask

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt, input logic [31:0] w, input bit legal);
      int n;
      set_fields(m, rs, rt, rd, sh, imm, tgt);
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else if (legal) begin
         sb.push_back('{addr: exp_addr, word: w});
         exp_addr++;
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      chk("clear_blocks_ready", {31'b0, in_ready}, 32'd0);
      step();
      clear = 1'b0;
      exp_addr = '0;
      @(negedge clk);
      chk("clear_count", {29'b0, count}, 32'd0);
      chk("clear_full", {31'b0, full}, 32'd0);
      chk("clear_err", {31'b0, err}, 32'd0);
      step();
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; im_ack = 1'b1;
      set_fields('0, '0, '0, '0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_im_we", {31'b0, im_we}, 32'd0);
      chk("rst_im_addr", {30'b0, im_addr}, 32'd0);
      chk("rst_im_wdata", im_wdata, 32'd0);
      chk("rst_count", {29'b0, count}, 32'd0);
      chk("rst_full", {31'b0, full}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      step();

      // single add
      send(5'(MN_ADD), 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1820, 1'b1);
      step();
      @(negedge clk);
      chk("t1_count", {29'b0, count}, 32'd1);
      step();

      // back-to-back lw, j from address 0
      do_clear();
      send(5'(MN_LW), 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8FA8_0004, 1'b1);
      send(5'(MN_J), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 32'h0800_0010, 1'b1);
      step(); step();
      @(negedge clk);
      chk("t2_count", {29'b0, count}, 32'd2);
      step();

      // sll with rs driven, write stalled three cycles
      im_ack = 1'b0;
      send(5'(MN_SLL), 5'd7, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0, 32'h0001_1100, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_stall_ready", {31'b0, in_ready}, 32'd0);
         chk("t3_stall_we", {31'b0, im_we}, 32'd1);
         step();
      end
      im_ack = 1'b1;
      step();
      @(negedge clk);
      chk("t3_count", {29'b0, count}, 32'd3);
      step();

      // illegal id dropped, next legal word lands on the same address
      send(5'd27, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("t4_no_we", {31'b0, im_we}, 32'd0);
      chk("t4_err", {31'b0, err}, 32'd1);
      chk("t4_count", {29'b0, count}, 32'd3);
      step();
      send(5'(MN_ORI), 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3422_1234, 1'b1);
      step();
      @(negedge clk);
      chk("t4_full_count", {29'b0, count}, 32'd4);
      chk("t4_full", {31'b0, full}, 32'd1);
      chk("t4_full_ready", {31'b0, in_ready}, 32'd0);
      chk("t4_err_sticky", {31'b0, err}, 32'd1);
      step();

      // fill from empty: four accepted, fifth refused
      do_clear();
      send(5'(MN_SUB), 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0, 32'h0085_3022, 1'b1);
      send(5'(MN_AND), 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0, 32'h0021_0824, 1'b1);
      send(5'(MN_SLTI), 5'd2, 5'd3, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h2843_FFFF, 1'b1);
      send(5'(MN_JAL), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 32'h0FFF_FFFF, 1'b1);
      set_fields(5'(MN_LUI), 5'd5, 5'd7, 5'd0, 5'd0, 16'hABCD, 26'h0);
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_fifth_ready", {31'b0, in_ready}, 32'd0);
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("t5_full", {31'b0, full}, 32'd1);
      chk("t5_count", {29'b0, count}, 32'd4);
      step();
      do_clear();
      send(5'(MN_LUI), 5'd5, 5'd7, 5'd0, 5'd0, 16'hABCD, 26'h0, 32'h3C07_ABCD, 1'b1);
      step();
      @(negedge clk);
      chk("t5_after_clear_count", {29'b0, count}, 32'd1);
      step();

      // reset while holding an unacknowledged write
      im_ack = 1'b0;
      send(5'(MN_JALR), 5'd31, 5'd9, 5'd31, 5'd3, 16'h0, 26'h0, 32'h03E0_F809, 1'b1);
      @(negedge clk);
      chk("t6_hold_we", {31'b0, im_we}, 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      im_ack = 1'b1;
      if (sb.size() != 0) void'(sb.pop_back());
      exp_addr = '0;
      @(negedge clk);
      chk("t6_rst_we", {31'b0, im_we}, 32'd0);
      chk("t6_rst_count", {29'b0, count}, 32'd0);
      chk("t6_rst_wdata", im_wdata, 32'd0);
      step();
      send(5'(MN_JR), 5'd31, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h03E0_0008, 1'b1);
      send(5'(MN_SRLV), 5'd3, 5'd4, 5'd5, 5'd9, 16'h0, 26'h0, 32'h0064_2806, 1'b1);
      step(); step();
      @(negedge clk);
      chk("t6_final_count", {29'b0, count}, 32'd2);
      chk("sb_drained", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_encoder_loader.md
Name: imem_encoder_loader

Overview:
Encoder counterpart to the control decoder. Accepts symbolic instruction requests (mnemonic id plus fields), packs each into a 32-bit MIPS instruction word, and writes the words into consecutive instruction-memory locations through a stallable write port. Used by the bench and boot path to load programs into IM without hand-assembled hex.

Parameters:
DEPTH, 128, number of IM words that can be written; the address counter covers 0..DEPTH-1.
AW, 7, IM word-address width; DEPTH <= 2**AW.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
clear  in  1  restarts loading at address 0; clears count, full and err
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_mnem  in  5  mnemonic id (package enum)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_shamt  in  5  shift amount
in_imm  in  16  immediate
in_target  in  26  jump target
im_we  out  1  write request (valid)
im_ack  in  1  memory accepts the write when im_we & im_ack
im_addr  out  AW  word address
im_wdata  out  32  encoded instruction
count  out  AW+1  words committed to IM
full  out  1  count == DEPTH
err  out  1  sticky flag: an illegal mnemonic was seen

Behaviour:
- Reset (rst=1 at an edge): im_we=0, im_addr=0, im_wdata=0, count=0, full=0, err=0. A pending word is discarded.
- Encoding formats:
  - R-type: {6'b0, rs, rt, rd, shamt, funct}.
  - jr: rt=rd=shamt=0.
  - jalr: rt=0, shamt=0, rd taken from in_rd.
  - sll and srl: rs forced to 0.
  - sllv and srlv: shamt forced to 0.
  - I-type: {op, rs, rt, imm}. lui forces rs=0.
  - J-type: {op, target}.
- Funct values: add 20, addu 21, sub 22, subu 23, and 24, or 25, nor 27, slt 2A, sltu 2B, sll 00, srl 02, sllv 04, srlv 06, jr 08, jalr 09 (hex).
- Opcode values: addi 08, slti 0A, andi 0C, ori 0D, lui 0F, beq 04, bne 05, j 02, jal 03, lw 23, sw 2B (hex).
- Pipeline: one output register.
  - Request accepted in cycle N gives im_we=1 in cycle N+1, with im_addr equal to the address held by the write-pointer register.
  - im_we, im_addr and im_wdata stay stable until im_ack.
- Handshake: in_ready = ~clear & ~full_next_guard & (~im_we | im_ack).
  - full_next_guard is 1 when count plus the pending word equals DEPTH.
  - A back-to-back accept with im_ack gives one word per cycle.
- Commit: on im_we & im_ack, count increments and the write pointer increments.
  - full asserts in the cycle after the DEPTH-th commit.
  - The pointer never wraps: once full, in_ready stays 0 until clear or rst.
- Illegal mnemonic (ids 26-31): accepted with in_ready=1 and dropped. No IM write, no address advance. err set (sticky).
- clear behaves like rst, except any in-flight im_we is dropped next cycle. clear has priority over a simultaneous request, which is not accepted.
- States: IDLE (im_we=0) and HOLD (im_we=1).
  - IDLE to HOLD on a legal accept.
  - HOLD to IDLE on im_ack with no new accept.
  - HOLD to HOLD on im_ack together with an accept, or while waiting for ack.
  - rst or clear returns to IDLE.

Decomposition:
- Shared package mips_isa_pkg:
  - mnemonic enum 0..25, in order: add sub and or slt sltu addu subu sll nor srl sllv srlv jr jalr addi ori lw sw beq lui slti bne andi j jal.
  - opcode and funct localparams.
  - MNEM_ILLEGAL_MIN = 26.
- One combinational sub-module, mips_encode: mnemonic plus fields in, {word, legal} out.
- The loader holds the handshake, the pointer, the counters and the flags.

Test Plan:
1. After rst, request add rs=1 rt=2 rd=3 → next cycle im_we=1, im_addr=0, im_wdata=0x00221820; im_ack=1 → count=1.
2. Request lw rt=8 rs=29 imm=4, then j target=0x10, with im_ack=1 throughout → wdata 0x8FA80004 at addr 0 and 0x08000010 at addr 1 on consecutive cycles.
3. Request sll rd=2 rt=1 shamt=4 with rs=7 driven, and hold im_ack=0 for 3 cycles → im_wdata stays 0x00011100 and in_ready stays 0 until the ack.
4. Request mnemonic 27 → no im_we, err=1, count unchanged; a following legal request is written at the same address.
5. DEPTH=4 with 5 back-to-back requests → 4 writes, then full=1 and in_ready=0; clear → count=0, full=0, err=0, next write at addr 0.
6. Assert rst while in HOLD with im_ack=0 → im_we=0 on the next cycle, count=0, and no write committed.
